controlador_porta: RTL and testbench

- Sequential motor controller for the automatic door; sits directly downstream of the door-opener logic and consumes its open-request output F as input abrir.
- Drives open/close motor commands from limit switches and an obstruction sensor.
- Holds the door open for a programmable time, reverses on obstruction and flags a sticky fault on travel timeout or inconsistent sensors.

---
 rtl/controlador_porta.sv | 116 +++++++++++
 tb/tb_controlador_porta.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/controlador_porta.sv
// Automatic door motor controller: open/hold/close sequencing, obstruction reversal, sticky fault.
// Optional CONTADOR_CICLOS_EN adds a saturating 16-bit completed-cycle counter on port ciclos.
module controlador_porta #(
  parameter int unsigned HOLD_CYCLES  = 50,
  parameter int unsigned MOVE_TIMEOUT = 200,
  parameter int unsigned CNT_W        = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        abrir,
  input  logic        fim_aberta,
  input  logic        fim_fechada,
  input  logic        obstaculo,
  output logic        motor_abre,
  output logic        motor_fecha,
  output logic        porta_aberta,
`ifdef CONTADOR_CICLOS_EN
  output logic [15:0] ciclos,
`endif
  output logic        falha
);

  typedef enum logic [2:0] {
    FECHADA  = 3'd0,
    ABRINDO  = 3'd1,
    ABERTA   = 3'd2,
    FECHANDO = 3'd3,
    FALHA    = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] MOVE_LAST = CNT_W'(MOVE_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             motor_abre_d, motor_fecha_d, porta_aberta_d, falha_d;

  // State, counter and registered Moore outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FECHADA;
      cnt_q        <= '0;
      motor_abre   <= 1'b0;
      motor_fecha  <= 1'b0;
      porta_aberta <= 1'b0;
      falha        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      motor_abre   <= motor_abre_d;
      motor_fecha  <= motor_fecha_d;
      porta_aberta <= porta_aberta_d;
      falha        <= falha_d;
    end
  end

  // Saturating increment: the counter is only compared, never allowed to wrap
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

  // Next state and counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_inc;
    unique case (state_q)
      FECHADA: begin
        cnt_d = '0;
        if (abrir) state_d = ABRINDO;
      end
      ABRINDO: begin
        if (fim_aberta)              state_d = ABERTA;
        else if (cnt_q == MOVE_LAST) state_d = FALHA;
      end
      ABERTA: begin
        if (abrir)                   cnt_d   = '0;
        else if (cnt_q == HOLD_LAST) state_d = FECHANDO;
      end
      FECHANDO: begin
        if (abrir || obstaculo)      state_d = ABRINDO;
        else if (fim_fechada)        state_d = FECHADA;
        else if (cnt_q == MOVE_LAST) state_d = FALHA;
      end
      FALHA: cnt_d = '0;
      default: state_d = FALHA;
    endcase
    // Both limit switches active at once means the sensors cannot be trusted
    if (fim_aberta && fim_fechada) state_d = FALHA;
    if (state_d != state_q) cnt_d = '0;
  end

  // Moore output decode from current state
  always_comb begin
    motor_abre_d   = 1'b0;
    motor_fecha_d  = 1'b0;
    porta_aberta_d = 1'b0;
    falha_d        = 1'b0;
    unique case (state_q)
      ABRINDO:  motor_abre_d   = 1'b1;
      ABERTA:   porta_aberta_d = 1'b1;
      FECHANDO: motor_fecha_d  = 1'b1;
      FALHA:    falha_d        = 1'b1;
      default:  ;
    endcase
  end

`ifdef CONTADOR_CICLOS_EN
  // Completed open/close cycles, counted on FECHANDO -> FECHADA
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ciclos <= 16'd0;
    end else if (state_q == FECHANDO && state_d == FECHADA && ciclos != 16'hFFFF) begin
      ciclos <= ciclos + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_controlador_porta.sv
// Directed bench for controlador_porta with HOLD_CYCLES=4, MOVE_TIMEOUT=8, CNT_W=4.
// Outputs are checked as {motor_abre, motor_fecha, porta_aberta, falha}, 1 ns after each rising edge.
module tb_controlador_porta;

  logic        clk;
  logic        rst_n;
  logic        abrir;
  logic        fim_aberta;
  logic        fim_fechada;
  logic        obstaculo;
  logic        motor_abre;
  logic        motor_fecha;
  logic        porta_aberta;
  logic        falha;
`ifdef CONTADOR_CICLOS_EN
  logic [15:0] ciclos;
`endif

  int vectors;
  int miscompares;

  controlador_porta #(
    .HOLD_CYCLES (4),
    .MOVE_TIMEOUT(8),
    .CNT_W       (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .abrir       (abrir),
    .fim_aberta  (fim_aberta),
    .fim_fechada (fim_fechada),
    .obstaculo   (obstaculo),
    .motor_abre  (motor_abre),
    .motor_fecha (motor_fecha),
    .porta_aberta(porta_aberta),
`ifdef CONTADOR_CICLOS_EN
    .ciclos      (ciclos),
`endif
    .falha       (falha)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] exp);
    logic [3:0] obs;
    obs = {motor_abre, motor_fecha, porta_aberta, falha};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed {ma,mf,pa,fa}=%b expected %b", tag, obs, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic [3:0] exp);
    @(posedge clk);
    #1;
    chk(tag, exp);
  endtask

  task automatic chk_ciclos(input string tag, input int exp);
`ifdef CONTADOR_CICLOS_EN
    vectors++;
    assert (ciclos === 16'(exp)) else begin
      miscompares++;
      $error("FAIL %s: observed ciclos=%0d expected %0d", tag, ciclos, exp);
    end
`else
    if (exp < 0) $display("unused %s", tag);
`endif
  endtask

  // Assert reset between edges, check immediate effect, release away from an edge
  task automatic do_reset(input string tag);
    #3 rst_n = 1'b0;
    #1 chk(tag, 4'b0000);
    @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    abrir       = 1'b0;
    fim_aberta  = 1'b0;
    fim_fechada = 1'b0;
    obstaculo   = 1'b0;

    cyc("reset", 4'b0000);
    chk_ciclos("reset_ciclos", 0);
    #2 rst_n = 1'b1;
    cyc("idle", 4'b0000);

    // Normal cycle: 3 cycles opening, 4 held open, 3 closing
    abrir = 1'b1;
    cyc("n_req", 4'b0000);
    abrir = 1'b0;
    cyc("n_open1", 4'b1000);
    cyc("n_open2", 4'b1000);
    fim_aberta = 1'b1;
    cyc("n_open3", 4'b1000);
    cyc("n_hold1", 4'b0010);
    cyc("n_hold2", 4'b0010);
    cyc("n_hold3", 4'b0010);
    fim_aberta = 1'b0;
    cyc("n_hold4", 4'b0010);
    cyc("n_close1", 4'b0100);
    cyc("n_close2", 4'b0100);
    fim_fechada = 1'b1;
    cyc("n_close3", 4'b0100);
    cyc("n_closed", 4'b0000);
    chk_ciclos("n_ciclos", 1);

    // Hold extension: abrir high for 10 cycles in ABERTA gives 14 open cycles
    abrir = 1'b1;
    cyc("h_req", 4'b0000);
    abrir       = 1'b0;
    fim_fechada = 1'b0;
    cyc("h_open1", 4'b1000);
    cyc("h_open2", 4'b1000);
    fim_aberta = 1'b1;
    cyc("h_open3", 4'b1000);
    abrir = 1'b1;
    repeat (10) cyc("h_held", 4'b0010);
    abrir = 1'b0;
    repeat (4) cyc("h_tail", 4'b0010);
    fim_aberta = 1'b0;
    cyc("h_close1", 4'b0100);

    // Obstruction on the 2nd closing cycle reverses the motor
    obstaculo = 1'b1;
    cyc("o_close2", 4'b0100);
    obstaculo = 1'b0;
    cyc("o_reverse", 4'b1000);
    chk_ciclos("o_ciclos", 1);

    // Sensor conflict while held open
    fim_aberta = 1'b1;
    cyc("c_open", 4'b1000);
    fim_fechada = 1'b1;
    cyc("c_aberta", 4'b0010);
    cyc("c_falha", 4'b0001);
    fim_aberta  = 1'b0;
    fim_fechada = 1'b0;
    abrir       = 1'b1;
    cyc("c_sticky", 4'b0001);
    abrir = 1'b0;
    cyc("c_sticky2", 4'b0001);
    do_reset("c_reset");
    chk_ciclos("c_ciclos_rst", 0);

    // Travel timeout: 8 cycles of motor_abre then fault
    abrir = 1'b1;
    cyc("t_req", 4'b0000);
    abrir = 1'b0;
    repeat (8) cyc("t_move", 4'b1000);
    cyc("t_falha", 4'b0001);
    abrir = 1'b1;
    cyc("t_ign1", 4'b0001);
    abrir = 1'b0;
    cyc("t_ign2", 4'b0001);
    cyc("t_ign3", 4'b0001);
    do_reset("t_reset");
    cyc("t_after", 4'b0000);

    // Async reset mid-opening, then idle with abrir low
    abrir = 1'b1;
    cyc("a_req", 4'b0000);
    abrir = 1'b0;
    cyc("a_open", 4'b1000);
    do_reset("a_reset");
    repeat (3) cyc("a_idle", 4'b0000);
    chk_ciclos("a_ciclos", 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
